// File: rtl/elevator_pkg.sv
// Shared types and codes for the elevator request scheduler.
// Holds the default floor count, state encodings and direction codes.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF = 10;
  localparam int FLOOR_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_UP   = 2'd1,
    ST_SERVE_DOWN = 2'd2,
    ST_DOOR       = 2'd3
  } state_e;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_DOWN = 2'b11;

endpackage

// File: rtl/floor_search.sv
// Combinational finder over the pending bitmap: nearest pending floor at or
// above / at or below the car, plus strict above/below presence flags.
module floor_search
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  up_found,
  output logic [FLOOR_W-1:0]    up_floor,
  output logic                  dn_found,
  output logic [FLOOR_W-1:0]    dn_floor,
  output logic                  any_above,
  output logic                  any_below
);

  always_comb begin
    up_found  = 1'b0;
    up_floor  = '0;
    dn_found  = 1'b0;
    dn_floor  = '0;
    any_above = 1'b0;
    any_below = 1'b0;
    // Descending scan so the last hit is the lowest floor at or above the car.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i >= int'(current_floor))) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i]) begin
        if (i <= int'(current_floor)) begin
          dn_found = 1'b1;
          dn_floor = FLOOR_W'(i);
        end
        if (i > int'(current_floor)) any_above = 1'b1;
        if (i < int'(current_floor)) any_below = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK-policy request scheduler: latches floor requests, picks the next target
// for the elevator FSM and times the door dwell.
//
// state         | meaning
// ST_IDLE       | no travel; target follows the car, direction none
// ST_SERVE_UP   | heading to the lowest pending floor at or above the car
// ST_SERVE_DOWN | heading to the highest pending floor at or below the car
// ST_DOOR       | door open, dwell down-counter running
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = NUM_FLOORS_DEF,
  parameter int DOOR_CYCLES = 10000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [3:0]            req_floor,
  input  logic [3:0]            current_floor,
  input  logic                  car_idle,
  output logic [3:0]            target_floor,
  output logic [1:0]            direction,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  req_drop
);

  localparam int                 DWELL_W    = $clog2(DOOR_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DOOR_CYCLES);

  state_e                  state_q, state_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [FLOOR_W-1:0]      target_q, target_d;
  logic [1:0]              dir_q, dir_d;
  logic [DWELL_W-1:0]      dwell_q, dwell_d;
  logic                    drop_q, drop_d;

  logic                    up_found, dn_found, any_above, any_below;
  logic [FLOOR_W-1:0]      up_floor, dn_floor;
  logic [NUM_FLOORS-1:0]   cur_mask, req_mask, set_mask, clr_mask;
  logic                    req_ok, restart, pend_here;

  floor_search #(.NUM_FLOORS(NUM_FLOORS)) u_search (
    .pending       (pending_q),
    .current_floor (current_floor),
    .up_found      (up_found),
    .up_floor      (up_floor),
    .dn_found      (dn_found),
    .dn_floor      (dn_floor),
    .any_above     (any_above),
    .any_below     (any_below)
  );

  // Out-of-range floors shift the one-hot mask off the end and become zero.
  assign cur_mask  = NUM_FLOORS'(1) << current_floor;
  assign req_mask  = NUM_FLOORS'(1) << req_floor;
  assign pend_here = |(pending_q & cur_mask);
  assign req_ok    = req_valid && (int'(req_floor) < NUM_FLOORS);
  assign restart   = (state_q == ST_DOOR) && req_ok && (req_floor == current_floor);

  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    clr_mask = '0;
    drop_d   = req_valid && !req_ok;
    case (state_q)
      ST_IDLE: begin
        if (pend_here) begin
          state_d  = ST_DOOR;
          clr_mask = cur_mask;
          dwell_d  = DWELL_LOAD;
        end else if (any_above) begin
          state_d = ST_SERVE_UP;
        end else if (any_below) begin
          state_d = ST_SERVE_DOWN;
        end
      end
      ST_SERVE_UP, ST_SERVE_DOWN: begin
        if (car_idle && (current_floor == target_q) && pend_here) begin
          state_d  = ST_DOOR;
          clr_mask = cur_mask;
          dwell_d  = DWELL_LOAD;
        end
      end
      ST_DOOR: begin
        if (restart) begin
          dwell_d = DWELL_LOAD;
        end else if (dwell_q <= DWELL_W'(1)) begin
          dwell_d = '0;
          // LOOK: keep going the way we came; an undirected stop prefers up.
          if (dir_q == DIR_DOWN) begin
            state_d = any_below ? ST_SERVE_DOWN : (any_above ? ST_SERVE_UP : ST_IDLE);
          end else begin
            state_d = any_above ? ST_SERVE_UP : (any_below ? ST_SERVE_DOWN : ST_IDLE);
          end
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    set_mask  = (req_ok && !restart) ? req_mask : '0;
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_comb begin
    target_d = current_floor;
    dir_d    = DIR_NONE;
    case (state_q)
      ST_SERVE_UP: begin
        target_d = up_found ? up_floor : current_floor;
        dir_d    = DIR_UP;
      end
      ST_SERVE_DOWN: begin
        target_d = dn_found ? dn_floor : current_floor;
        dir_d    = DIR_DOWN;
      end
      ST_DOOR: dir_d = dir_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      target_q  <= '0;
      dir_q     <= DIR_NONE;
      dwell_q   <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      dwell_q   <= dwell_d;
      drop_q    <= drop_d;
    end
  end

  assign target_floor = target_q;
  assign direction    = dir_q;
  assign door_open    = (state_q == ST_DOOR);
  assign pending      = pending_q;
  assign req_drop     = drop_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios plus random traffic
// compared every cycle against a behavioural LOOK scheduler model.
module tb_elevator_request_scheduler;

  localparam int NF = 10;
  localparam int DC = 4;
  localparam int MD_IDLE = 0, MD_UP = 1, MD_DOWN = 2, MD_DOOR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_floor = '0;
  logic [3:0]    current_floor = '0;
  logic          car_idle = 1'b1;
  logic [3:0]    target_floor;
  logic [1:0]    direction;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          req_drop;

  elevator_request_scheduler #(.NUM_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .current_floor (current_floor),
    .car_idle      (car_idle),
    .target_floor  (target_floor),
    .direction     (direction),
    .door_open     (door_open),
    .pending       (pending),
    .req_drop      (req_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode, pending set as an array, signed travel direction,
  // and the number of dwell cycles already spent with the door open.
  int m_mode, m_target, m_dir, m_seen;
  bit m_drop;
  bit m_pend [NF];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NF-1:0] m_pend_vec();
    logic [NF-1:0] v = '0;
    for (int f = 0; f < NF; f++) v[f] = m_pend[f];
    return v;
  endfunction

  function automatic logic [1:0] m_dir_code();
    if (m_dir > 0) return 2'b10;
    if (m_dir < 0) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_target = 0; m_dir = 0; m_seen = 0; m_drop = 1'b0;
    for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
  endtask

  task automatic model_step();
    int  cur = int'(current_floor);
    int  rf  = int'(req_floor);
    int  nmode = m_mode;
    int  clr = -1;
    int  lo = -1, hi = -1;
    bit  above = 1'b0, below = 1'b0, here, ok, restart;
    for (int f = 0; f < NF; f++) begin
      if (m_pend[f]) begin
        if (f > cur) above = 1'b1;
        if (f < cur) below = 1'b1;
        if (f >= cur && lo < 0) lo = f;
        if (f <= cur) hi = f;
      end
    end
    here    = (cur < NF) && m_pend[cur];
    ok      = req_valid && (rf < NF);
    restart = (m_mode == MD_DOOR) && ok && (rf == cur);
    m_drop  = req_valid && !ok;
    case (m_mode)
      MD_IDLE: begin
        if (here) begin nmode = MD_DOOR; clr = cur; m_seen = 0; end
        else if (above) nmode = MD_UP;
        else if (below) nmode = MD_DOWN;
      end
      MD_UP, MD_DOWN: begin
        if (car_idle && cur == m_target && here) begin
          nmode = MD_DOOR; clr = cur; m_seen = 0;
        end
      end
      default: begin
        if (restart) m_seen = 0;
        else begin
          m_seen++;
          if (m_seen >= DC) begin
            if (m_dir < 0) nmode = below ? MD_DOWN : (above ? MD_UP : MD_IDLE);
            else           nmode = above ? MD_UP : (below ? MD_DOWN : MD_IDLE);
          end
        end
      end
    endcase
    case (m_mode)
      MD_UP:   begin m_target = (lo >= 0) ? lo : cur; m_dir = 1;  end
      MD_DOWN: begin m_target = (hi >= 0) ? hi : cur; m_dir = -1; end
      MD_DOOR: m_target = cur;
      default: begin m_target = cur; m_dir = 0; end
    endcase
    if (ok && !restart) m_pend[rf] = 1'b1;
    if (clr >= 0) m_pend[clr] = 1'b0;
    m_mode = nmode;
  endtask

  task automatic compare_all();
    chk("target",    32'(target_floor), 32'(m_target));
    chk("direction", 32'(direction),    32'(m_dir_code()));
    chk("door_open", 32'(door_open),    32'(m_mode == MD_DOOR));
    chk("pending",   32'(pending),      32'(m_pend_vec()));
    chk("req_drop",  32'(req_drop),     32'(m_drop));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic req(input int f);
    req_valid = 1'b1;
    req_floor = 4'(f);
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic wait_door(output int n);
    int t = 0;
    n = 0;
    while (!door_open && t < 40) begin cycle(); t++; end
    if (!door_open) chk("door_start", 32'(door_open), 32'd1);
    else while (door_open && n < 40) begin n++; cycle(); end
  endtask

  initial begin
    int n;
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    cycle();
    cycle();
    rst = 1'b0;

    // Single request from the lobby, served with a full dwell.
    current_floor = 4'd0;
    req(3);
    chk("s1_pending", 32'(pending), 32'h008);
    cycle();
    cycle();
    chk("s1_target", 32'(target_floor), 32'd3);
    chk("s1_dir", 32'(direction), 32'(2'b10));
    current_floor = 4'd3;
    wait_door(n);
    chk("s1_dwell", 32'(n), 32'(DC));
    chk("s1_pending_clr", 32'(pending), 32'h000);
    cycle();
    chk("s1_dir_idle", 32'(direction), 32'(2'b00));

    // Retarget mid-travel to an intermediate floor, then resume.
    current_floor = 4'd2;
    cycle();
    req(7);
    cycle();
    cycle();
    chk("s2_target7", 32'(target_floor), 32'd7);
    req(5);
    cycle();
    chk("s2_retarget", 32'(target_floor), 32'd5);
    current_floor = 4'd5;
    wait_door(n);
    chk("s2_dwell", 32'(n), 32'(DC));
    cycle();
    chk("s2_resume", 32'(target_floor), 32'd7);
    current_floor = 4'd7;
    wait_door(n);

    // LOOK sweep: up to 8, then reverse down to 1.
    current_floor = 4'd3;
    cycle();
    req(4);
    req(8);
    req(1);
    cycle();
    chk("s3_target4", 32'(target_floor), 32'd4);
    current_floor = 4'd4;
    wait_door(n);
    cycle();
    chk("s3_target8", 32'(target_floor), 32'd8);
    chk("s3_dir_up", 32'(direction), 32'(2'b10));
    current_floor = 4'd8;
    wait_door(n);
    cycle();
    chk("s3_target1", 32'(target_floor), 32'd1);
    chk("s3_dir_down", 32'(direction), 32'(2'b11));
    current_floor = 4'd1;
    wait_door(n);

    // Out-of-range request is dropped with a single-cycle pulse.
    req(12);
    chk("s4_drop", 32'(req_drop), 32'd1);
    chk("s4_pending", 32'(pending), 32'h000);
    cycle();
    chk("s4_drop_end", 32'(req_drop), 32'd0);

    // Same-floor request during dwell restarts the door timer.
    current_floor = 4'd6;
    req(6);
    cycle();
    cycle();
    cycle();
    req(6);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (door_open) n++;
      cycle();
    end
    chk("s5_restart", 32'(n), 32'(DC));
    chk("s5_pending", 32'(pending), 32'h000);

    // Asynchronous reset while serving downward discards everything at once.
    current_floor = 4'd9;
    cycle();
    req(4);
    req(5);
    req(6);
    req(7);
    cycle();
    cycle();
    chk("s6_dir", 32'(direction), 32'(2'b11));
    chk("s6_target", 32'(target_floor), 32'd7);
    chk("s6_pending", 32'(pending), 32'h0F0);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_pending", 32'(pending), 32'h000);
    chk("s6_rst_target", 32'(target_floor), 32'd0);
    chk("s6_rst_dir", 32'(direction), 32'd0);
    chk("s6_rst_door", 32'(door_open), 32'd0);
    chk("s6_rst_drop", 32'(req_drop), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    current_floor = 4'd0;
    cycle();

    // Random traffic with a car that walks toward the model's target.
    for (int k = 0; k < 3000; k++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_floor = 4'($urandom_range(0, 12));
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
      cycle();
      if ($urandom_range(0, 1) == 1 && int'(current_floor) != m_target) begin
        if (int'(current_floor) < m_target) current_floor = current_floor + 4'd1;
        else current_floor = current_floor - 4'd1;
      end
      car_idle = (int'(current_floor) == m_target);
    end
    req_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (0..NUM_FLOORS-1).
REQ-002 SHALL have parameter DOOR_CYCLES, default 10000000, door dwell length in clk cycles (minimum 1).
REQ-003 SHALL have port clk, input, 1, the single clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, one-cycle request strobe.
REQ-006 SHALL have port req_floor, input, 4, floor requested when req_valid=1.
REQ-007 SHALL have port current_floor, input, 4, car position from the elevator FSM.
REQ-008 SHALL have port car_idle, input, 1, elevator FSM is in its idle state.
REQ-009 SHALL have port target_floor, output, 4, registered floor the elevator FSM drives toward.
REQ-010 SHALL have port direction, output, 2, 00 none, 10 up, 11 down.
REQ-011 SHALL have port door_open, output, 1, high throughout dwell.
REQ-012 SHALL have port pending, output, NUM_FLOORS, latched request bitmap.
REQ-013 SHALL have port req_drop, output, 1, one-cycle pulse when a request is rejected.

Function
REQ-014 SHALL set pending[req_floor] on the clock edge after req_valid=1 when req_floor < NUM_FLOORS.
REQ-015 SHALL ignore req_floor >= NUM_FLOORS, leave pending unchanged and pulse req_drop for one cycle, one cycle after the strobe.
REQ-016 SHALL implement states IDLE, SERVE_UP, SERVE_DOWN, DOOR.
REQ-017 SHALL, in IDLE with pending=0, hold target_floor=current_floor and direction=00.
REQ-018 SHALL, in IDLE, go to DOOR if pending[current_floor]=1; else to SERVE_UP if any pending bit is above current_floor; else to SERVE_DOWN if any is below. Priority: DOOR, then up.
REQ-019 SHALL, in SERVE_UP, drive target_floor to the lowest pending floor >= current_floor and direction=10.
REQ-020 SHALL, in SERVE_DOWN, drive target_floor to the highest pending floor <= current_floor and direction=11.
REQ-021 SHALL enter DOOR when car_idle=1 and current_floor==target_floor with that floor pending, clearing that pending bit on the same edge.
REQ-022 SHALL, in DOOR, hold door_open=1 for exactly DOOR_CYCLES cycles with target_floor=current_floor, then leave DOOR.
REQ-023 SHALL, on leaving DOOR, continue in the previous direction if pending bits remain in that direction, else reverse if bits remain opposite, else go to IDLE (LOOK policy).
REQ-024 SHALL, on a request for current_floor while in DOOR, restart the dwell counter and not set the pending bit.
REQ-025 SHALL, when a request and a clear hit the same floor on the same edge, leave the bit cleared.
REQ-026 SHALL update target_floor and direction one cycle after the state or pending change that causes them (registered outputs).
REQ-027 SHALL retarget mid-travel: a new request lying between current_floor and target_floor in the travel direction becomes the target on the next cycle.
REQ-028 SHALL count dwell with a counter of width clog2(DOOR_CYCLES+1) that never wraps.

Reset
REQ-029 SHALL, on rst=1, asynchronously force state=IDLE, pending=0, target_floor=0, direction=00, door_open=0, req_drop=0 and dwell counter=0.
REQ-030 SHALL discard all pending requests when reset is asserted mid-operation, including during DOOR.

Structure
REQ-031 SHALL take NUM_FLOORS default, state encodings and direction codes from shared package elevator_pkg.
REQ-032 SHALL use one sub-module, floor_search, a combinational nearest-pending-above/below finder over the pending bitmap.

Verification (DOOR_CYCLES=4, NUM_FLOORS=10)
REQ-033 SHALL cover: reset, then request floor 3 with car at 0 -> pending=0x008, SERVE_UP, target 3; car_idle at 3 -> door_open for 4 cycles, pending=0, IDLE.
REQ-034 SHALL cover: car at 2 moving up to 7; request 5 -> target becomes 5 next cycle; after dwell at 5, target becomes 7.
REQ-035 SHALL cover: pending {1,8}, car at 4 leaving DOOR going up -> serves 8, then reverses to 1, direction 10 then 11.
REQ-036 SHALL cover: request floor 12 -> req_drop pulses 1 cycle, pending unchanged.
REQ-037 SHALL cover: request current floor 6 at dwell cycle 3 -> dwell restarts, door_open high for 4 more cycles.
REQ-038 SHALL cover: rst asserted during SERVE_DOWN with pending=0x0F0 -> all outputs and pending return to reset values immediately.
